// File: rtl/rv32imc_1p_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle fast paths for divide-by-zero and signed overflow.
module rv32imc_1p_muldiv #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_dati,
   input  logic [XLEN-1:0] rs2_dati,
   input  logic [4:0]      rd_addr_i,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] rd_dato,
   output logic [4:0]      rd_addr,
   output logic            c_rf_write
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StIter = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]      state_q;
   logic [2:0]      op_q;
   logic [4:0]      cnt_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] hi_q, lo_q, b_q;
   logic            neg_q, rneg_q, fast_q, done_q;

   // Operand decode at accept
   logic            accept, is_div, a_signed, b_signed, a_neg, b_neg;
   logic            div_zero, div_ovf, fast;
   logic [XLEN-1:0] mag_a, mag_b, fast_res;

   assign accept   = start && (state_q != StIter);
   assign is_div   = funct3[2];
   assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
   assign b_signed = is_div ? ~funct3[0] : ~funct3[1];
   assign a_neg    = a_signed && rs1_dati[XLEN-1];
   assign b_neg    = b_signed && rs2_dati[XLEN-1];
   assign mag_a    = a_neg ? -rs1_dati : rs1_dati;
   assign mag_b    = b_neg ? -rs2_dati : rs2_dati;
   assign div_zero = is_div && (rs2_dati == '0);
   assign div_ovf  = is_div && !funct3[0] && (rs1_dati == {1'b1, {(XLEN-1){1'b0}}})
                     && (rs2_dati == '1);
   assign fast     = div_zero || div_ovf;
   assign fast_res = div_zero ? (funct3[1] ? rs1_dati : '1)
                              : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

   // One iteration step; hi/lo hold partial product or remainder/quotient
   logic [XLEN:0]   mul_sum, div_trial;
   logic            div_ok;
   logic [XLEN-1:0] hi_n, lo_n;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_trial = {hi_q, lo_q[XLEN-1]} - {1'b0, b_q};
      div_ok    = ~div_trial[XLEN];
      if (op_q[2]) begin
         hi_n = div_ok ? div_trial[XLEN-1:0] : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
         lo_n = {lo_q[XLEN-2:0], div_ok};
      end else begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   // Sign applied once to the magnitude result
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, result;

   always_comb begin
      prod   = {hi_q, lo_q};
      prod_s = neg_q ? -prod : prod;
      quo_s  = neg_q ? -lo_q : lo_q;
      rem_s  = rneg_q ? -hi_q : hi_q;
      if (fast_q)       result = hi_q;
      else if (op_q[2]) result = op_q[1] ? rem_s : quo_s;
      else              result = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         op_q    <= '0;
         cnt_q   <= '0;
         rd_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         fast_q  <= 1'b0;
      end else if (accept) begin
         state_q <= fast ? StDone : StIter;
         op_q    <= funct3;
         cnt_q   <= '0;
         rd_q    <= rd_addr_i;
         hi_q    <= fast ? fast_res : '0;
         lo_q    <= is_div ? mag_a : mag_b;
         b_q     <= is_div ? mag_b : mag_a;
         neg_q   <= a_neg ^ b_neg;
         rneg_q  <= a_neg;
         fast_q  <= fast;
      end else if (state_q == StIter) begin
         hi_q  <= hi_n;
         lo_q  <= lo_n;
         cnt_q <= cnt_q + 5'd1;
         if (cnt_q == 5'd31) state_q <= StDone;
      end else if (state_q == StDone) begin
         state_q <= StIdle;
      end
   end

   // Result is registered out of DONE, so done pulses one cycle after DONE is entered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q  <= 1'b0;
         rd_dato <= '0;
         rd_addr <= '0;
      end else if (state_q == StDone) begin
         done_q  <= 1'b1;
         rd_dato <= result;
         rd_addr <= rd_q;
      end else begin
         done_q  <= 1'b0;
      end
   end

   assign busy       = (state_q == StIter);
   assign done       = done_q;
   assign c_rf_write = done_q && (rd_addr != 5'd0);

endmodule

// File: tb/tb_rv32imc_1p_muldiv.sv
// Directed self-checking bench for rv32imc_1p_muldiv: vector table plus
// hand-written ignore-start and mid-operation reset sequences.
module tb_rv32imc_1p_muldiv;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] rs1_dati = '0, rs2_dati = '0;
   logic [4:0]  rd_addr_i = '0;
   logic        busy, done, c_rf_write;
   logic [31:0] rd_dato;
   logic [4:0]  rd_addr;

   rv32imc_1p_muldiv #(.XLEN(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .funct3     (funct3),
      .rs1_dati   (rs1_dati),
      .rs2_dati   (rs2_dati),
      .rd_addr_i  (rd_addr_i),
      .busy       (busy),
      .done       (done),
      .rd_dato    (rd_dato),
      .rd_addr    (rd_addr),
      .c_rf_write (c_rf_write)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] res;
      int          lat;
      logic        wr;
   } vec_t;

   vec_t vecs[17];

   // Accept at the posedge after the call; latency counts edges until done is seen
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output int lat,
                         output logic wr, output logic [4:0] rda, output logic busy0,
                         output logic pulse_next);
      @(negedge clk);
      start = 1'b1; funct3 = f; rs1_dati = a; rs2_dati = b; rd_addr_i = rd;
      @(posedge clk); #1;
      start = 1'b0;
      busy0 = busy;
      lat = 0; res = 'x; wr = 1'bx; rda = 'x; pulse_next = 1'bx;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i; res = rd_dato; wr = c_rf_write; rda = rd_addr;
            break;
         end
      end
      @(posedge clk); #1;
      pulse_next = done;
   endtask

   logic [31:0] r;
   int          lat;
   logic        wr, b0, pn;
   logic [4:0]  rda;
   int          dones;

   initial begin
      vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 1'b1};
      vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33, 1'b1};
      vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33, 1'b1};
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33, 1'b1};
      vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD, 33, 1'b1};
      vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF, 33, 1'b1};
      vecs[6]  = '{3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        33, 1'b1};
      vecs[7]  = '{3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         33, 1'b1};
      vecs[8]  = '{3'b100, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1,  1'b1};
      vecs[9]  = '{3'b110, 32'd5,         32'd0,         5'd14, 32'd5,         1,  1'b1};
      vecs[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0,         1,  1'b1};
      vecs[11] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1,  1'b1};
      vecs[12] = '{3'b101, 32'd5,         32'd0,         5'd17, 32'hFFFF_FFFF, 1,  1'b1};
      vecs[13] = '{3'b111, 32'd5,         32'd0,         5'd18, 32'd5,         1,  1'b1};
      vecs[14] = '{3'b000, 32'd3,         32'd4,         5'd0,  32'd12,        33, 1'b0};
      vecs[15] = '{3'b000, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 5'd19, 32'd6,         33, 1'b1};
      vecs[16] = '{3'b001, 32'hFFFF_FFFE, 32'd3,         5'd20, 32'hFFFF_FFFF, 33, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset c_rf_write", {31'd0, c_rf_write}, 32'd0);
      check("reset rd_dato", rd_dato, 32'd0);
      check("reset rd_addr", {27'd0, rd_addr}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, r, lat, wr, rda, b0, pn);
         check($sformatf("v%0d result", i), r, vecs[i].res);
         check($sformatf("v%0d latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d c_rf_write", i), {31'd0, wr}, {31'd0, vecs[i].wr});
         check($sformatf("v%0d rd_addr", i), {27'd0, rda}, {27'd0, vecs[i].rd});
         check($sformatf("v%0d busy after accept", i), {31'd0, b0},
               {31'd0, (vecs[i].lat > 1)});
         check($sformatf("v%0d done one cycle", i), {31'd0, pn}, 32'd0);
      end

      // start pulsed during ITER must be ignored
      @(negedge clk);
      start = 1'b1; funct3 = 3'b000; rs1_dati = 32'd7; rs2_dati = 32'hFFFF_FFFD; rd_addr_i = 5'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1; funct3 = 3'b101; rs1_dati = 32'd100; rs2_dati = 32'd7; rd_addr_i = 5'd9;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; dones = 0; r = 'x; rda = 'x;
      for (int i = 6; i <= 80; i++) begin
         @(posedge clk); #1;
         if (done) begin
            dones++;
            if (lat == 0) begin
               lat = i; r = rd_dato; rda = rd_addr;
            end
         end
      end
      check("ignore result", r, 32'hFFFF_FFEB);
      check("ignore latency", lat, 33);
      check("ignore rd_addr", {27'd0, rda}, 32'd3);
      check("ignore single done", dones, 1);

      // asynchronous reset in the middle of ITER aborts the op
      @(negedge clk);
      start = 1'b1; funct3 = 3'b101; rs1_dati = 32'd100; rs2_dati = 32'd7; rd_addr_i = 5'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midreset busy", {31'd0, busy}, 32'd0);
      check("midreset done", {31'd0, done}, 32'd0);
      check("midreset c_rf_write", {31'd0, c_rf_write}, 32'd0);
      check("midreset rd_dato", rd_dato, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || c_rf_write) dones++;
      end
      check("midreset no write-back", dones, 0);

      run_op(3'b101, 32'd100, 32'd7, 5'd4, r, lat, wr, rda, b0, pn);
      check("post-reset DIVU result", r, 32'd14);
      check("post-reset DIVU latency", lat, 33);
      check("post-reset DIVU c_rf_write", {31'd0, wr}, 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish required finish");
      $fatal(1);
   end

endmodule
